// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the 64-point FFT front end: frame geometry, the
// complex-sample word type and the loader FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int D_WIDTH     = 64;  // samples per frame
  localparam int LOG_2_WIDTH = 6;   // log2(D_WIDTH)
  localparam int SAMPLE_W    = 16;  // bits per real/imag component

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    WAIT  = 2'd1,
    START = 2'd2
  } loader_state_t;

endpackage

// File: rtl/compute_timer.sv
// -----------------------------------------------------------------------------
// compute_timer
// Loadable down-counter measuring how long the FFT core needs after start.
// Clocked on the falling edge to match the FFT datapath.
// Ports:
//   clk    in  clock (falling edge active)
//   rst    in  asynchronous active-low reset
//   load   in  load counter with COMPUTE_CYCLES at this edge
//   busy   out counter is nonzero
//   expire out one-cycle pulse registered on the edge the count goes 1 -> 0
// -----------------------------------------------------------------------------
module compute_timer #(
  parameter int COMPUTE_CYCLES = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy,
  output logic expire
);

  localparam int CNT_W = $clog2(COMPUTE_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_expire;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_expire <= 1'b0;
    end else begin
      r_expire <= (r_cnt == CNT_W'(1));
      if (load) begin
        r_cnt <= CNT_W'(COMPUTE_CYCLES);
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign busy   = (r_cnt != '0);
  assign expire = r_expire;

endmodule

// File: rtl/fft_frame_loader.sv
// -----------------------------------------------------------------------------
// fft_frame_loader
// Collects complex samples from a valid/ready stream into a parallel frame in
// arrival order, then issues a one-cycle start strobe to the FFT core. A
// compute timer holds off the next start until the core's result is stable.
// All state updates on the falling edge of clk.
// Ports:
//   clk, rst           clock (falling edge) / async active-low reset
//   s_valid, s_ready   sample handshake
//   s_re, s_im         sample components (two's complement)
//   mode_ifft          direction, captured with the first sample of a frame
//   flush              discard partially filled (or waiting) frame
//   frame_re, frame_im parallel frame, word k at bits [16*k +: 16]
//   fft_start          one-cycle start strobe
//   fft_ifft           direction for the frame just started, held
//   busy               compute timer running
//   result_valid       one-cycle pulse when FFT output is stable
// -----------------------------------------------------------------------------
module fft_frame_loader #(
  parameter int D_WIDTH        = fft_pkg::D_WIDTH,
  parameter int LOG_2_WIDTH    = fft_pkg::LOG_2_WIDTH,
  parameter int COMPUTE_CYCLES = 200
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [fft_pkg::SAMPLE_W-1:0]        s_re,
  input  logic [fft_pkg::SAMPLE_W-1:0]        s_im,
  input  logic                                mode_ifft,
  input  logic                                flush,
  output logic [fft_pkg::SAMPLE_W*D_WIDTH-1:0] frame_re,
  output logic [fft_pkg::SAMPLE_W*D_WIDTH-1:0] frame_im,
  output logic                                fft_start,
  output logic                                fft_ifft,
  output logic                                busy,
  output logic                                result_valid
);

  import fft_pkg::*;

  loader_state_t          r_state;
  loader_state_t          w_next;
  logic [LOG_2_WIDTH-1:0] r_wr_ptr;
  logic                   r_armed;
  logic                   r_pend_ifft;
  logic                   r_fft_start;
  logic                   r_fft_ifft;
  sample_t                r_re [D_WIDTH];
  sample_t                r_im [D_WIDTH];

  logic w_xfer;
  logic w_last;
  logic w_timer_busy;
  logic w_timer_expire;
  logic w_timer_load;

  // s_ready stays low during reset and for the first edge after release.
  assign s_ready      = (r_state == FILL) && r_armed;
  // A flushed edge drops any sample presented with it.
  assign w_xfer       = s_valid && s_ready && !flush;
  assign w_last       = (r_wr_ptr == LOG_2_WIDTH'(D_WIDTH - 1));
  // The timer is loaded on the edge that leaves START.
  assign w_timer_load = (r_state == START);

  compute_timer #(
    .COMPUTE_CYCLES(COMPUTE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (w_timer_load),
    .busy  (w_timer_busy),
    .expire(w_timer_expire)
  );

  // Timer idle is judged on the pre-decrement value, so a stalled frame
  // starts on the edge after result_valid rises, never together with it.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      FILL: begin
        if (w_xfer && w_last) begin
          w_next = w_timer_busy ? WAIT : START;
        end
      end
      WAIT: begin
        if (flush) begin
          w_next = FILL;
        end else if (!w_timer_busy) begin
          w_next = START;
        end
      end
      START:   w_next = FILL;
      default: w_next = FILL;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= FILL;
      r_armed     <= 1'b0;
      r_wr_ptr    <= '0;
      r_pend_ifft <= 1'b0;
      r_fft_start <= 1'b0;
      r_fft_ifft  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_armed     <= 1'b1;
      // Strobe is high exactly while the FSM sits in START.
      r_fft_start <= (w_next == START);
      if (w_next == START) begin
        r_fft_ifft <= r_pend_ifft;
      end
      if (flush && (r_state != START)) begin
        r_wr_ptr <= '0;
      end else if (w_xfer) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;  // wraps naturally at D_WIDTH
      end
      if (w_xfer && (r_wr_ptr == '0)) begin
        r_pend_ifft <= mode_ifft;
      end
    end
  end

  // Frame storage: written only on accepted transfers, so it is frozen in
  // WAIT and START and never cleared except by reset.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < D_WIDTH; k++) begin
        r_re[k] <= '0;
        r_im[k] <= '0;
      end
    end else if (w_xfer) begin
      r_re[r_wr_ptr] <= sample_t'(s_re);
      r_im[r_wr_ptr] <= sample_t'(s_im);
    end
  end

  for (genvar k = 0; k < D_WIDTH; k++) begin : g_pack
    assign frame_re[SAMPLE_W*k +: SAMPLE_W] = r_re[k];
    assign frame_im[SAMPLE_W*k +: SAMPLE_W] = r_im[k];
  end

  assign fft_start    = r_fft_start;
  assign fft_ifft     = r_fft_ifft;
  assign busy         = w_timer_busy;
  assign result_valid = w_timer_expire;

endmodule
